// File: rtl/mac_job_controller.sv
// Job sequencer for the MAC datapath: accepts a job, streams its
// operand beats, waits out the pipeline latency, then presents the result.
module mac_job_controller #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int PIPE_DEPTH     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [MAC_CONF_WIDTH-1:0] cmd_cfg,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic                      op_valid,
  output logic                      op_ready,
  output logic                      mac_en,
  output logic [MAC_CONF_WIDTH-1:0] mac_cfg,
  output logic                      mac_acc_clr,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRN_LOAD = DW'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]             drn_q, drn_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q, cfg_d;
  logic                      first_q, first_d;
  logic                      err_q, err_d;
  logic                      beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      cfg_q   <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      cfg_q   <= cfg_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign beat = (state_q == RUN) && op_valid && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    cfg_d   = cfg_q;
    first_d = first_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cfg_d   = cmd_cfg;
          cnt_d   = cmd_len;
          first_d = 1'b1;
          // Reserved lane mode falls back to single lane
          if (cmd_cfg[1:0] == 2'b11) begin
            cfg_d[1:0] = 2'b00;
            err_d      = 1'b1;
          end
          if (cmd_len == '0) begin
            state_d = DRAIN;
            drn_d   = DRN_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          cnt_d   = cnt_q - 1'b1;
          first_d = 1'b0;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
            drn_d   = DRN_LOAD;
          end
        end
      end
      DRAIN: begin
        first_d = 1'b0;
        drn_d   = drn_q - 1'b1;
        if (drn_q == DW'(1)) state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A zero-length job still clears the accumulator, in its first drain cycle
  assign cmd_ready   = !rst && (state_q == IDLE);
  assign op_ready    = !rst && (state_q == RUN);
  assign mac_en      = beat;
  assign mac_acc_clr = (beat && first_q)
                    || (!rst && state_q == DRAIN && first_q);
  assign res_valid   = !rst && (state_q == DONE);
  assign busy        = !rst && (state_q != IDLE);
  assign mac_cfg     = cfg_q;
  assign cfg_err     = err_q;

endmodule
